// File: rtl/commit_trace_monitor.sv
// Commit-side trace monitor: captures retired PCs/flags into a FWFT FIFO, keeps
// saturating statistics and a sticky halt. Optional PC-sequence check: TRACE_SEQ_CHECK_EN.
module commit_trace_monitor #(
  parameter int DEPTH = 16,
  parameter int CNT_W = 32
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic [31:0]                i_pc_debug,
  input  logic                       i_insn_vld,
  input  logic                       i_ctrl,
  input  logic                       i_mispred,
  input  logic                       i_halt,
  output logic                       o_rd_valid,
  input  logic                       i_rd_ready,
  output logic [31:0]                o_rd_pc,
  output logic [1:0]                 o_rd_flags,
  output logic [$clog2(DEPTH):0]     o_level,
  output logic [CNT_W-1:0]           o_retired,
  output logic [CNT_W-1:0]           o_ctrl_cnt,
  output logic [CNT_W-1:0]           o_mispred_cnt,
  output logic [CNT_W-1:0]           o_dropped,
  output logic                       o_halted,
  output logic                       o_seq_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALTED} state_e;

  state_e            state_q, state_d;
  logic [31:0]       mem_pc [DEPTH];
  logic [1:0]        mem_fl [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rd_next;
  logic [LW-1:0]     level_q, level_d;
  logic [31:0]       rd_pc_q, rd_pc_d;
  logic [1:0]        rd_fl_q, rd_fl_d;
  logic [CNT_W-1:0]  ret_q, ret_d, ctrl_q, ctrl_d, mis_q, mis_d, drop_q, drop_d;
  logic              capture, empty, full, pop, push;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    return (en && (v != '1)) ? v + CNT_W'(1) : v;
  endfunction

  assign capture = (state_q != S_HALTED) && i_insn_vld;
  assign empty   = (level_q == '0);
  assign full    = (level_q == LW'(DEPTH));
  assign pop     = !empty && i_rd_ready;
  assign push    = capture && (!full || pop);
  assign rd_next = rd_ptr_q + AW'(1);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (i_halt) state_d = S_HALTED; else if (i_insn_vld) state_d = S_RUN;
      S_RUN:    if (i_halt) state_d = S_HALTED;
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_next : rd_ptr_q;
    level_d  = level_q + LW'(push) - LW'(pop);
    rd_pc_d  = rd_pc_q;
    rd_fl_d  = rd_fl_q;
    // The head register must track whichever entry becomes the head at this edge,
    // including an incoming push that lands in an empty (or emptying) FIFO.
    if (push && (empty || (pop && level_q == LW'(1)))) begin
      rd_pc_d = i_pc_debug;
      rd_fl_d = {i_ctrl, i_mispred};
    end else if (pop && level_q > LW'(1)) begin
      rd_pc_d = mem_pc[rd_next];
      rd_fl_d = mem_fl[rd_next];
    end
    ret_d  = sat_inc(ret_q,  capture);
    ctrl_d = sat_inc(ctrl_q, capture && i_ctrl);
    mis_d  = sat_inc(mis_q,  capture && i_ctrl && i_mispred);
    drop_d = sat_inc(drop_q, capture && full && !pop);
  end

  // NOTE: every register here uses <=, so all reads in this edge see pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      rd_pc_q  <= '0;
      rd_fl_q  <= '0;
      ret_q    <= '0;
      ctrl_q   <= '0;
      mis_q    <= '0;
      drop_q   <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      rd_pc_q  <= rd_pc_d;
      rd_fl_q  <= rd_fl_d;
      ret_q    <= ret_d;
      ctrl_q   <= ctrl_d;
      mis_q    <= mis_d;
      drop_q   <= drop_d;
    end
  end

  // NOTE: storage is not reset; entries are only ever read behind a valid level.
  always_ff @(posedge i_clk) begin
    if (push) begin
      mem_pc[wr_ptr_q] <= i_pc_debug;
      mem_fl[wr_ptr_q] <= {i_ctrl, i_mispred};
    end
  end

`ifdef TRACE_SEQ_CHECK_EN
  logic        have_prev_q, prev_ctrl_q, seq_err_q;
  logic [31:0] prev_pc_q;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      have_prev_q <= 1'b0;
      prev_ctrl_q <= 1'b0;
      prev_pc_q   <= '0;
      seq_err_q   <= 1'b0;
    end else if (capture) begin
      have_prev_q <= 1'b1;
      prev_ctrl_q <= i_ctrl;
      prev_pc_q   <= i_pc_debug;
      if (have_prev_q && !prev_ctrl_q && (i_pc_debug != prev_pc_q + 32'd4))
        seq_err_q <= 1'b1;
    end
  end

  assign o_seq_err = seq_err_q;
`else
  assign o_seq_err = 1'b0;
`endif

  assign o_rd_valid    = !empty;
  assign o_rd_pc       = rd_pc_q;
  assign o_rd_flags    = rd_fl_q;
  assign o_level       = level_q;
  assign o_retired     = ret_q;
  assign o_ctrl_cnt    = ctrl_q;
  assign o_mispred_cnt = mis_q;
  assign o_dropped     = drop_q;
  assign o_halted      = (state_q == S_HALTED);
endmodule

// File: tb/tb_commit_trace_monitor.sv
// Bench for commit_trace_monitor: directed scenarios plus randomized traffic
// against a queue-based reference model (narrow counters to reach saturation).
module tb_commit_trace_monitor;
  localparam int DEPTH = 16;
  localparam int CNT_W = 6;
  localparam int LW    = $clog2(DEPTH) + 1;
  localparam longint CMAX = (64'd1 << CNT_W) - 1;

  logic              i_clk = 1'b0;
  logic              i_reset = 1'b0;
  logic [31:0]       i_pc_debug = '0;
  logic              i_insn_vld = 1'b0, i_ctrl = 1'b0, i_mispred = 1'b0, i_halt = 1'b0;
  logic              i_rd_ready = 1'b0;
  logic              o_rd_valid, o_halted, o_seq_err;
  logic [31:0]       o_rd_pc;
  logic [1:0]        o_rd_flags;
  logic [LW-1:0]     o_level;
  logic [CNT_W-1:0]  o_retired, o_ctrl_cnt, o_mispred_cnt, o_dropped;

  int checks = 0;
  int failures = 0;

  commit_trace_monitor #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_pc_debug(i_pc_debug), .i_insn_vld(i_insn_vld),
    .i_ctrl(i_ctrl), .i_mispred(i_mispred), .i_halt(i_halt), .o_rd_valid(o_rd_valid),
    .i_rd_ready(i_rd_ready), .o_rd_pc(o_rd_pc), .o_rd_flags(o_rd_flags), .o_level(o_level),
    .o_retired(o_retired), .o_ctrl_cnt(o_ctrl_cnt), .o_mispred_cnt(o_mispred_cnt),
    .o_dropped(o_dropped), .o_halted(o_halted), .o_seq_err(o_seq_err)
  );

  always #5 i_clk = ~i_clk;

  typedef struct { logic [31:0] pc; logic [1:0] flags; } ent_t;
  ent_t        mq[$];
  longint      m_ret, m_ctrl, m_mis, m_drop;
  bit          m_halted, m_has_prev, m_prev_ctrl, m_seq;
  logic [31:0] m_prev_pc;

  function automatic longint sat(input longint v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_ret = 0; m_ctrl = 0; m_mis = 0; m_drop = 0;
    m_halted = 0; m_has_prev = 0; m_prev_ctrl = 0; m_seq = 0; m_prev_pc = '0;
  endtask

  task automatic do_reset(input bit vld_during);
    i_reset = 1'b1; i_insn_vld = vld_during; i_halt = 1'b0;
    i_rd_ready = vld_during; i_pc_debug = 32'hdead_0000;
    model_reset();
    @(posedge i_clk); #1;
    i_reset = 1'b0; i_insn_vld = 1'b0; i_rd_ready = 1'b0;
  endtask

  // One clock: drive inputs, advance the model by the trace rules, then sample.
  task automatic cyc(input bit vld, input logic [31:0] pc, input bit ctrl, input bit mis,
                     input bit halt, input bit rdy);
    bit cap, pop, was_full;
    i_insn_vld = vld; i_pc_debug = pc; i_ctrl = ctrl; i_mispred = mis;
    i_halt = halt; i_rd_ready = rdy;
    cap      = !m_halted && vld;
    was_full = (mq.size() == DEPTH);
    pop      = (mq.size() != 0) && rdy;
    if (pop) void'(mq.pop_front());
    if (cap) begin
      m_ret = sat(m_ret);
      if (ctrl) m_ctrl = sat(m_ctrl);
      if (ctrl && mis) m_mis = sat(m_mis);
      if (was_full && !pop) m_drop = sat(m_drop);
      else mq.push_back('{pc: pc, flags: {ctrl, mis}});
`ifdef TRACE_SEQ_CHECK_EN
      if (m_has_prev && !m_prev_ctrl && pc != m_prev_pc + 32'd4) m_seq = 1;
`endif
      m_has_prev = 1; m_prev_ctrl = ctrl; m_prev_pc = pc;
    end
    if (!m_halted && halt) m_halted = 1;
    @(posedge i_clk); #1;
    i_insn_vld = 1'b0; i_halt = 1'b0; i_rd_ready = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(1'b0);
    checks++;
    if ({o_rd_valid, o_level, o_rd_pc, o_rd_flags, o_halted, o_seq_err} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got valid=%b level=%0d pc=%h flags=%b halted=%b seq=%b want all 0",
               o_rd_valid, o_level, o_rd_pc, o_rd_flags, o_halted, o_seq_err);
    end
    checks++;
    if ({o_retired, o_ctrl_cnt, o_mispred_cnt, o_dropped} !== '0) begin
      failures++;
      $display("FAIL reset_counters: got %0d/%0d/%0d/%0d want 0/0/0/0",
               o_retired, o_ctrl_cnt, o_mispred_cnt, o_dropped);
    end
  endtask

  task automatic test_order();
    logic [31:0] exp_pc;
    do_reset(1'b0);
    for (int i = 0; i < 3; i++) cyc(1, 32'(4 * i), 0, 0, 0, 0);
    checks++;
    if (o_level !== LW'(3) || o_retired !== CNT_W'(3)) begin
      failures++;
      $display("FAIL order_fill: got level=%0d retired=%0d want 3/3", o_level, o_retired);
    end
    for (int i = 0; i < 3; i++) begin
      exp_pc = 32'(4 * i);
      checks++;
      if (o_rd_valid !== 1'b1 || o_rd_pc !== exp_pc) begin
        failures++;
        $display("FAIL order_pop%0d: got valid=%b pc=%h want 1/%h", i, o_rd_valid, o_rd_pc, exp_pc);
      end
      cyc(0, 0, 0, 0, 0, 1);
    end
    cyc(0, 0, 0, 0, 0, 1);
    checks++;
    if (o_rd_valid !== 1'b0 || o_level !== '0) begin
      failures++;
      $display("FAIL order_empty: got valid=%b level=%0d want 0/0", o_rd_valid, o_level);
    end
  endtask

  task automatic test_overflow_and_full_pushpop();
    do_reset(1'b0);
    for (int i = 0; i < 20; i++) cyc(1, 32'h100 + 32'(4 * i), 0, 0, 0, 0);
    checks++;
    if (o_level !== LW'(16) || o_dropped !== CNT_W'(4) || o_retired !== CNT_W'(20) || o_rd_pc !== 32'h100) begin
      failures++;
      $display("FAIL overflow: got level=%0d dropped=%0d retired=%0d head=%h want 16/4/20/100",
               o_level, o_dropped, o_retired, o_rd_pc);
    end
    cyc(1, 32'h200, 1, 0, 0, 1);
    checks++;
    if (o_level !== LW'(16) || o_dropped !== CNT_W'(4) || o_rd_pc !== 32'h104 || o_retired !== CNT_W'(21)) begin
      failures++;
      $display("FAIL full_pushpop: got level=%0d dropped=%0d head=%h retired=%0d want 16/4/104/21",
               o_level, o_dropped, o_rd_pc, o_retired);
    end
    for (int i = 0; i < 15; i++) cyc(0, 0, 0, 0, 0, 1);
    checks++;
    if (o_level !== LW'(1) || o_rd_pc !== 32'h200 || o_rd_flags !== 2'b10) begin
      failures++;
      $display("FAIL full_pushpop_tail: got level=%0d head=%h flags=%b want 1/200/10",
               o_level, o_rd_pc, o_rd_flags);
    end
    cyc(1, 32'h300, 0, 0, 0, 0);
    do_reset(1'b1);
    checks++;
    if ({o_rd_valid, o_level, o_rd_pc, o_rd_flags, o_halted, o_seq_err,
         o_retired, o_ctrl_cnt, o_mispred_cnt, o_dropped} !== '0) begin
      failures++;
      $display("FAIL midstream_reset: got valid=%b level=%0d pc=%h retired=%0d dropped=%0d want all 0",
               o_rd_valid, o_level, o_rd_pc, o_retired, o_dropped);
    end
  endtask

  task automatic test_ctrl_seq();
    bit exp_seq;
`ifdef TRACE_SEQ_CHECK_EN
    exp_seq = 1'b1;
`else
    exp_seq = 1'b0;
`endif
    do_reset(1'b0);
    cyc(1, 32'h10, 1, 1, 0, 0);
    cyc(1, 32'h40, 0, 0, 0, 0);
    checks++;
    if (o_ctrl_cnt !== CNT_W'(1) || o_mispred_cnt !== CNT_W'(1) || o_seq_err !== 1'b0) begin
      failures++;
      $display("FAIL ctrl_counts: got ctrl=%0d mis=%0d seq=%b want 1/1/0", o_ctrl_cnt, o_mispred_cnt, o_seq_err);
    end
    cyc(1, 32'h48, 0, 1, 0, 0);
    checks++;
    if (o_seq_err !== exp_seq || o_mispred_cnt !== CNT_W'(1) || o_ctrl_cnt !== CNT_W'(1)) begin
      failures++;
      $display("FAIL seq_err: got seq=%b mis=%0d ctrl=%0d want %b/1/1", o_seq_err, o_mispred_cnt, o_ctrl_cnt, exp_seq);
    end
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1);
    checks++;
    if (o_rd_pc !== 32'h48 || o_rd_flags !== 2'b01) begin
      failures++;
      $display("FAIL mispred_no_ctrl_stored: got pc=%h flags=%b want 48/01", o_rd_pc, o_rd_flags);
    end
  endtask

  task automatic test_halt();
    do_reset(1'b0);
    cyc(1, 32'h1c, 0, 0, 0, 0);
    cyc(1, 32'h20, 0, 0, 1, 0);
    checks++;
    if (o_halted !== 1'b1 || o_retired !== CNT_W'(2) || o_level !== LW'(2)) begin
      failures++;
      $display("FAIL halt_capture: got halted=%b retired=%0d level=%0d want 1/2/2", o_halted, o_retired, o_level);
    end
    for (int i = 0; i < 3; i++) cyc(1, 32'h24 + 32'(4 * i), 1, 1, 0, 0);
    checks++;
    if (o_retired !== CNT_W'(2) || o_ctrl_cnt !== '0 || o_level !== LW'(2)) begin
      failures++;
      $display("FAIL halt_frozen: got retired=%0d ctrl=%0d level=%0d want 2/0/2", o_retired, o_ctrl_cnt, o_level);
    end
    cyc(1, 32'h50, 0, 0, 0, 1);
    checks++;
    if (o_rd_pc !== 32'h20 || o_level !== LW'(1)) begin
      failures++;
      $display("FAIL halt_drain1: got head=%h level=%0d want 20/1", o_rd_pc, o_level);
    end
    cyc(0, 0, 0, 0, 0, 1);
    checks++;
    if (o_level !== '0 || o_rd_valid !== 1'b0 || o_halted !== 1'b1) begin
      failures++;
      $display("FAIL halt_drain2: got level=%0d valid=%b halted=%b want 0/0/1", o_level, o_rd_valid, o_halted);
    end
    do_reset(1'b0);
    cyc(0, 0, 0, 0, 1, 0);
    cyc(1, 32'h60, 0, 0, 0, 0);
    checks++;
    if (o_halted !== 1'b1 || o_retired !== '0 || o_level !== '0) begin
      failures++;
      $display("FAIL halt_idle: got halted=%b retired=%0d level=%0d want 1/0/0", o_halted, o_retired, o_level);
    end
  endtask

  task automatic test_random();
    logic [31:0] pc;
    bit vld, ctrl, mis, halt, rdy;
    do_reset(1'b0);
    pc = 32'h1000;
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset($urandom_range(0, 1) == 1);
        pc = 32'h1000;
      end else begin
        vld  = ($urandom_range(0, 9) < 7);
        ctrl = ($urandom_range(0, 3) == 0);
        mis  = $urandom_range(0, 1) == 1;
        halt = ($urandom_range(0, 149) == 0);
        rdy  = ($urandom_range(0, 9) < ((n / 100) % 2 == 0 ? 3 : 8));
        if ($urandom_range(0, 29) == 0) pc = $urandom() & 32'hffff_fffc;
        cyc(vld, pc, ctrl, mis, halt, rdy);
        if (vld) pc = ctrl ? ($urandom() & 32'hffff_fffc) : pc + 32'd4;
      end
      checks++;
      if (o_rd_valid !== (mq.size() != 0) || o_level !== LW'(mq.size())) begin
        failures++;
        $display("FAIL rand_level@%0d: got valid=%b level=%0d want %b/%0d", n, o_rd_valid, o_level,
                 mq.size() != 0, mq.size());
      end
      if (mq.size() != 0) begin
        checks++;
        if (o_rd_pc !== mq[0].pc || o_rd_flags !== mq[0].flags) begin
          failures++;
          $display("FAIL rand_head@%0d: got pc=%h flags=%b want %h/%b", n, o_rd_pc, o_rd_flags,
                   mq[0].pc, mq[0].flags);
        end
      end
      checks++;
      if (o_retired !== m_ret[CNT_W-1:0] || o_ctrl_cnt !== m_ctrl[CNT_W-1:0] ||
          o_mispred_cnt !== m_mis[CNT_W-1:0] || o_dropped !== m_drop[CNT_W-1:0]) begin
        failures++;
        $display("FAIL rand_counters@%0d: got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d", n,
                 o_retired, o_ctrl_cnt, o_mispred_cnt, o_dropped, m_ret, m_ctrl, m_mis, m_drop);
      end
      checks++;
      if (o_halted !== m_halted || o_seq_err !== m_seq) begin
        failures++;
        $display("FAIL rand_flags@%0d: got halted=%b seq=%b want %b/%b", n, o_halted, o_seq_err, m_halted, m_seq);
      end
    end
  endtask

  initial begin
    model_reset();
    @(posedge i_clk); #1;
    test_reset();
    test_order();
    test_overflow_and_full_pushpop();
    test_ctrl_seq();
    test_halt();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/commit_trace_monitor.md
# commit_trace_monitor

Consumer for the pipelined core's commit-side debug trace (`o_pc_debug`, `o_insn_vld`, `o_ctrl`, `o_mispred`, `o_halt`). It sits beside the `pipelined` top level and records every retired instruction's PC and control flags into a FIFO. It keeps saturating retirement, control-transfer, misprediction and drop counters, and latches halt. A bench or on-chip debug port drains the FIFO through a valid/ready handshake.

## Interface
- `DEPTH`, 16, FIFO entries; power of two, at least 2
- `CNT_W`, 32, width of each statistics counter
- `i_clk` in 1, sole clock; all logic on the rising edge
- `i_reset` in 1, synchronous, active-high reset
- `i_pc_debug` in 32, PC of the retiring instruction
- `i_insn_vld` in 1, an instruction retires this cycle
- `i_ctrl` in 1, the retiring instruction is a branch or jump; qualified by `i_insn_vld`
- `i_mispred` in 1, the retiring control transfer was mispredicted; qualified by `i_insn_vld`
- `i_halt` in 1, the core signals halt
- `o_rd_valid` out 1, FIFO head is valid
- `i_rd_ready` in 1, consumer accepts the head entry
- `o_rd_pc` out 32, PC at the FIFO head
- `o_rd_flags` out 2, head flags {ctrl, mispred}
- `o_level` out $clog2(DEPTH)+1, number of entries in the FIFO
- `o_retired` out CNT_W, count of retired instructions
- `o_ctrl_cnt` out CNT_W, count of retired control transfers
- `o_mispred_cnt` out CNT_W, count of retired mispredictions
- `o_dropped` out CNT_W, count of retirements lost because the FIFO was full
- `o_halted` out 1, sticky halt indication
- `o_seq_err` out 1, sticky PC-sequence error; see Configuration

## Operation
- The FSM has three states:
  - IDLE: entered on reset. Moves to RUN on the first `i_insn_vld`, and that instruction is captured.
  - RUN: captures every retirement. On `i_halt`, moves to HALTED.
  - HALTED: all capture and counting are frozen. Only `i_reset` leaves this state.
- Capture (IDLE/RUN with `i_insn_vld`=1):
  - Pushes {`i_pc_debug`, `i_ctrl`, `i_mispred`} into the FIFO.
  - Increments `o_retired`; increments `o_ctrl_cnt` if `i_ctrl`; increments `o_mispred_cnt` if `i_ctrl && i_mispred`.
  - `i_mispred` without `i_ctrl` is ignored in the counters but is stored in the FIFO as given.
- `i_halt` together with `i_insn_vld` in the same cycle: the instruction is captured and counted first, then the FSM enters HALTED.
- `i_halt` without `i_insn_vld`: nothing is captured; the FSM enters HALTED.
- `i_halt` in IDLE also moves the FSM to HALTED.
- Every counter saturates at all-ones and never wraps.
- FIFO full, push requested, no pop this cycle: the entry is discarded and `o_dropped` increments. `o_retired` still increments.
- FIFO full with a push and a pop in the same cycle: both succeed and `o_level` is unchanged.
- Pop occurs when `o_rd_valid && i_rd_ready`. Pops remain allowed in HALTED so the consumer can drain after halt.
- `i_rd_ready` while the FIFO is empty has no effect.
- Read and write pointers are `$clog2(DEPTH)` bits wide and wrap modulo `DEPTH`. Full and empty are derived from `o_level`.

## Timing
- Reset (synchronous, `i_reset`=1 at a rising edge):
  - FSM to IDLE; pointers, `o_level` and all counters to 0.
  - `o_rd_valid`=0, `o_rd_pc`=0, `o_rd_flags`=0, `o_halted`=0, `o_seq_err`=0.
  - Reset asserted mid-operation discards all FIFO contents at that edge.
- Write latency: an entry pushed at edge N gives `o_rd_valid`=1 and the new `o_level` after edge N.
- Counters update at the same edge as the capture.
- The FIFO is first-word fall-through: `o_rd_pc` and `o_rd_flags` are registered and always show the head entry.
  - A pop at edge N presents the next entry after edge N. If the FIFO becomes empty, `o_rd_valid` drops after edge N.
- `o_halted` rises after the edge at which `i_halt` is sampled.
- There is no combinational path from any input to any output.

## Configuration
- `TRACE_SEQ_CHECK_EN` defined:
  - The block tracks the last captured PC and its ctrl flag.
  - On a capture whose predecessor had ctrl=0, if PC ≠ previous PC + 4 (mod 2^32), `o_seq_err` sets and stays set until reset.
  - The first capture after reset is never checked.
- `TRACE_SEQ_CHECK_EN` undefined: `o_seq_err` is tied to 0 and the tracking registers are not built.

## Test plan
- Reset, then 3 retirements with PC 0x0, 0x4, 0x8 and ctrl=0 -> `o_level`=3, `o_retired`=3, FIFO pops 0x0, 0x4, 0x8 in order with `i_rd_ready`=1.
- 20 back-to-back retirements into `DEPTH`=16 with `i_rd_ready`=0 -> `o_level`=16, `o_dropped`=4, `o_retired`=20, head PC is the first one captured.
- Retirement at PC 0x10 with ctrl=1, mispred=1, then at PC 0x40 with ctrl=0 -> `o_ctrl_cnt`=1, `o_mispred_cnt`=1, `o_seq_err`=0; then a retirement at PC 0x48 -> `o_seq_err`=1 (macro defined) or 0 (macro undefined).
- `i_halt` and `i_insn_vld` in the same cycle at PC 0x20, followed by more retirements -> PC 0x20 is captured, `o_halted`=1 on the next cycle, `o_retired` is frozen, and the FIFO still drains to `o_level`=0.
- FIFO full with a simultaneous push and pop -> `o_level` stays 16, `o_dropped` is unchanged; `i_reset` pulsed mid-stream -> all outputs return to 0 on the next cycle.
